interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Two-source prioritised interrupt controller that sequences interrupt entry and return for the 16-bit datapath. It latches rising edges on `int0`/`int1`, arbitrates by a programmable priority and by masks, and raises `intr` with a programmable 16-bit vector. It then tracks the active service level through acknowledge and return-from-interrupt, with one level of nesting. It sits between the external interrupt pins and the datapath's interrupt inputs, and is configured by the datapath through a small register file.

## Interface
- `VEC_W`, 16: width of the vector and config registers.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `int0`  in  1  raw interrupt request, source 0 (rising-edge sensitive).
- `int1`  in  1  raw interrupt request, source 1 (rising-edge sensitive).
- `cfgWrite`  in  1  config write strobe.
- `cfgAddr`  in  2  config register select: 0 = ENABLE, 1 = VEC0, 2 = VEC1, 3 = PRIO.
- `cfgDataIn`  in  16  config write data.
- `cfgDataOut`  out  16  combinational readback of the register at `cfgAddr`; unused bits read 0.
- `intAck`  in  1  datapath accepts the presented interrupt.
- `intDone`  in  1  datapath returns from the current handler.
- `intr`  out  1  interrupt request to the datapath.
- `intVector`  out  16  handler address of the presented request.
- `intLvl`  out  2  currently serviced source: 00 none, 01 int0, 10 int1.

## Operation
- Registers:
  - ENABLE: bit0 = en0, bit1 = en1, bit15 = global enable GE; other bits are not stored.
  - VEC0, VEC1: full 16 bits.
  - PRIO bit0: 0 means int0 outranks int1; 1 means int1 outranks int0.
- Edge capture:
  - `prevN` samples `intN` every cycle, including during `Reset`.
  - An edge (`intN & ~prevN`) sets `pendN`.
  - Pending bits latch regardless of masks.
- Eligible source: `pendN & enN & GE`, and strictly higher priority than the level at the top of the service stack (any source qualifies when the stack is empty). If both sources are eligible, the higher-priority one is selected.
- FSM states: IDLE, REQ, SERV.
  - IDLE → REQ when any source is eligible. The selected source and its vector are latched on this transition.
  - REQ: `intr`=1. On `intAck`: clear the selected source's pend bit, push its level onto the 2-entry stack, go to SERV. `intDone` is ignored in REQ.
  - SERV: on `intDone`, pop the stack; go to IDLE if the stack becomes empty, otherwise stay in SERV at the outer level. Without `intDone`, go to REQ if a strictly higher-priority source is eligible (nesting; the maximum depth of 2 follows).
- `intAck` outside REQ is ignored. `intDone` in IDLE is ignored.
- `intLvl` reflects the top of the stack. `intVector` holds its latched value until the next REQ entry.
- Simultaneous events:
  - An edge and an `intAck` clear of the same source in the same cycle: the set wins and the pend bit stays 1.
  - `intDone` and an eligible source in the same cycle: the pop completes first; the new request is evaluated the next cycle.
- Config writes take effect on the next edge. A write during REQ does not change the latched vector or source, and clearing an enable or GE does not withdraw a request already in REQ.
- Reset clears all registers, pend bits, the stack and the FSM (IDLE). Reset mid-handler discards the nesting state.

## Timing
- Reset values: `intr`=0, `intVector`=0, `intLvl`=00, `cfgDataOut`=0 for all addresses.
- Latency from `int0` rising before edge k (enabled):
  - `pend0`=1 after edge k.
  - `intr`=1 after edge k+1.
- `intAck` sampled at edge m: `intr`=0 and `intLvl` updated after edge m.
- `intDone` at edge m: `intLvl` is popped after edge m. A nested request can reassert `intr` no earlier than after edge m+1.
- A level held high on `intN` produces a single request; a new request requires a low-then-high transition.

## Test plan
- Reset, ENABLE=0x8001, VEC0=0x0040; pulse `int0` → `intr` is 1 two cycles later with `intVector`=0x0040; `intAck` → `intLvl`=01; `intDone` → `intLvl`=00, FSM in IDLE.
- PRIO=0, both enabled, `int0` and `int1` rise on the same cycle → int0 is presented first; after ack and done, int1 is presented with VEC1; PRIO=1 reverses the order.
- Nesting with PRIO=1: service int0 (`intLvl`=01), then `int1` edge → `intr` reasserts with VEC1, ack gives `intLvl`=10; first `intDone` → 01, second `intDone` → 00.
- Masking: GE=0 and `int1` pulsed → no `intr`, `pend1` held; write GE=1 → `intr` asserts the next cycle. A lower-priority edge during SERV does not preempt.
- `int0` held high through and after `Reset` → no request; `intr` stays 0.
- `intr` pending in REQ with `Reset` asserted → all outputs return to 0 the next cycle.
- Readback: write VEC1=0xBEEF, set `cfgAddr`=2 → `cfgDataOut`=0xBEEF; write ENABLE=0xFFFF → reads back 0x8003.

Source files
------------

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - two-source prioritised interrupt controller with one nesting level
//
// Purpose:
//    Latches rising edges on int0/int1, arbitrates them by mask and a
//    programmable priority, and presents one request at a time to the
//    datapath along with its vector. The service stack is two entries deep,
//    so a higher-priority source can preempt a running handler exactly once.
//
// Ports:
//    CLK         system clock, rising edge
//    Reset       synchronous active-high reset
//    int0, int1  raw interrupt requests (rising-edge sensitive)
//    cfgWrite    config register write strobe
//    cfgAddr     0 = ENABLE, 1 = VEC0, 2 = VEC1, 3 = PRIO
//    cfgDataIn   config write data
//    cfgDataOut  combinational readback of the register at cfgAddr
//    intAck      datapath accepts the presented request
//    intDone     datapath returns from the current handler
//    intr        request to the datapath
//    intVector   handler address of the presented request
//    intLvl      source in service: 00 none, 01 int0, 10 int1

module interrupt_controller #(
   parameter int VEC_W = 16
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             int0,
   input  logic             int1,
   input  logic             cfgWrite,
   input  logic [1:0]       cfgAddr,
   input  logic [VEC_W-1:0] cfgDataIn,
   output logic [VEC_W-1:0] cfgDataOut,
   input  logic             intAck,
   input  logic             intDone,
   output logic             intr,
   output logic [VEC_W-1:0] intVector,
   output logic [1:0]       intLvl
);

   typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

   state_t           state;
   logic             en0, en1, ge, prio;
   logic [VEC_W-1:0] vec0, vec1;
   logic             prev0, prev1;
   logic             pend0, pend1;
   logic [1:0]       depth;      // number of occupied stack entries
   logic             stk0, stk1; // source id per stack entry: 0 = int0, 1 = int1
   logic             sel;        // source latched for the current request

   logic edge0, edge1, top_src, elig0, elig1, any_elig, pick1, ack_go, clr0, clr1;

   always_comb begin
      edge0    = int0 & ~prev0;
      edge1    = int1 & ~prev1;
      top_src  = (depth == 2'd2) ? stk1 : stk0;
      // A source may only interrupt a handler it strictly outranks; a source
      // never outranks itself, so re-entry of the same source is impossible.
      elig0    = pend0 & en0 & ge & ((depth == 2'd0) | (top_src & ~prio));
      elig1    = pend1 & en1 & ge & ((depth == 2'd0) | (~top_src & prio));
      any_elig = elig0 | elig1;
      pick1    = elig1 & (~elig0 | prio);
      ack_go   = (state == REQ) & intAck;
      clr0     = ack_go & ~sel;
      clr1     = ack_go & sel;
   end

   always_comb begin
      if (depth == 2'd0)
         intLvl = 2'b00;
      else
         intLvl = top_src ? 2'b10 : 2'b01;
   end

   always_comb begin
      cfgDataOut = '0;
      case (cfgAddr)
         2'd0: begin
            cfgDataOut[0]       = en0;
            cfgDataOut[1]       = en1;
            cfgDataOut[VEC_W-1] = ge;
         end
         2'd1:    cfgDataOut    = vec0;
         2'd2:    cfgDataOut    = vec1;
         default: cfgDataOut[0] = prio;
      endcase
   end

   // Edge history keeps sampling through Reset so a level held high across
   // reset is not mistaken for a fresh edge afterwards.
   always_ff @(posedge CLK) begin
      prev0 <= int0;
      prev1 <= int1;
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state     <= IDLE;
         en0       <= 1'b0;
         en1       <= 1'b0;
         ge        <= 1'b0;
         prio      <= 1'b0;
         vec0      <= '0;
         vec1      <= '0;
         pend0     <= 1'b0;
         pend1     <= 1'b0;
         depth     <= 2'd0;
         stk0      <= 1'b0;
         stk1      <= 1'b0;
         sel       <= 1'b0;
         intr      <= 1'b0;
         intVector <= '0;
      end else begin
         if (cfgWrite) begin
            case (cfgAddr)
               2'd0: begin
                  en0 <= cfgDataIn[0];
                  en1 <= cfgDataIn[1];
                  ge  <= cfgDataIn[VEC_W-1];
               end
               2'd1:    vec0 <= cfgDataIn;
               2'd2:    vec1 <= cfgDataIn;
               default: prio <= cfgDataIn[0];
            endcase
         end

         // A new edge wins over the acknowledge clear in the same cycle.
         pend0 <= edge0 | (pend0 & ~clr0);
         pend1 <= edge1 | (pend1 & ~clr1);

         case (state)
            IDLE: begin
               if (any_elig) begin
                  state     <= REQ;
                  sel       <= pick1;
                  intVector <= pick1 ? vec1 : vec0;
                  intr      <= 1'b1;
               end
            end
            REQ: begin
               if (intAck) begin
                  state <= SERV;
                  intr  <= 1'b0;
                  if (depth == 2'd0)
                     stk0 <= sel;
                  else
                     stk1 <= sel;
                  if (depth != 2'd2)
                     depth <= depth + 2'd1;
               end
            end
            SERV: begin
               // A return is handled alone; new requests are looked at next cycle.
               if (intDone) begin
                  if (depth <= 2'd1) begin
                     depth <= 2'd0;
                     state <= IDLE;
                  end else begin
                     depth <= depth - 2'd1;
                  end
               end else if (any_elig) begin
                  state     <= REQ;
                  sel       <= pick1;
                  intVector <= pick1 ? vec1 : vec0;
                  intr      <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - scoreboard testbench for interrupt_controller

module tb_interrupt_controller;

   logic        CLK = 1'b0;
   logic        Reset = 1'b0;
   logic        int0 = 1'b0;
   logic        int1 = 1'b0;
   logic        cfgWrite = 1'b0;
   logic [1:0]  cfgAddr = 2'd0;
   logic [15:0] cfgDataIn = 16'h0;
   logic [15:0] cfgDataOut;
   logic        intAck = 1'b0;
   logic        intDone = 1'b0;
   logic        intr;
   logic [15:0] intVector;
   logic [1:0]  intLvl;

   typedef struct {
      logic [15:0] vec;
      logic [1:0]  lvl;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;

   interrupt_controller #(.VEC_W(16)) dut (
      .CLK(CLK), .Reset(Reset), .int0(int0), .int1(int1),
      .cfgWrite(cfgWrite), .cfgAddr(cfgAddr), .cfgDataIn(cfgDataIn),
      .cfgDataOut(cfgDataOut), .intAck(intAck), .intDone(intDone),
      .intr(intr), .intVector(intVector), .intLvl(intLvl)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      step();
      step();
      Reset = 1'b0;
   endtask

   task automatic cfg_wr(input logic [1:0] a, input logic [15:0] d);
      cfgWrite  = 1'b1;
      cfgAddr   = a;
      cfgDataIn = d;
      step();
      cfgWrite  = 1'b0;
   endtask

   task automatic push(input logic [15:0] v, input logic [1:0] l);
      exp_t e;
      e.vec = v;
      e.lvl = l;
      sb.push_back(e);
   endtask

   // Wait (bounded) for intr, then pop the scoreboard and check the vector.
   task automatic wait_req(output logic [1:0] lvl);
      int n = 0;
      exp_t e;
      lvl = 2'b00;
      while (!intr && n < 20) begin
         step();
         n++;
      end
      if (!intr) begin
         check("intr_timeout", intr, 1);
      end else if (sb.size() == 0) begin
         check("sb_underflow", 0, 1);
      end else begin
         e = sb.pop_front();
         check("vector", intVector, e.vec);
         lvl = e.lvl;
      end
   endtask

   task automatic present_ack();
      logic [1:0] l;
      wait_req(l);
      intAck = 1'b1;
      step();
      intAck = 1'b0;
      check("ack_intr", intr, 0);
      check("ack_lvl", intLvl, l);
   endtask

   task automatic finish_done(input logic [1:0] lvl);
      intDone = 1'b1;
      step();
      intDone = 1'b0;
      check("done_lvl", intLvl, lvl);
   endtask

   initial begin
      logic [1:0] l;

      // Reset state and readback of every address
      do_reset();
      check("rst_intr", intr, 0);
      check("rst_vec", intVector, 0);
      check("rst_lvl", intLvl, 0);
      for (int a = 0; a < 4; a++) begin
         cfgAddr = 2'(a);
         #1;
         check("rst_cfg", cfgDataOut, 0);
      end

      // Basic int0 request with latency checks
      cfg_wr(2'd0, 16'h8001);
      cfg_wr(2'd1, 16'h0040);
      push(16'h0040, 2'b01);
      int0 = 1'b1;
      step();
      int0 = 1'b0;
      check("lat_k", intr, 0);
      step();
      check("lat_k1", intr, 1);
      present_ack();
      finish_done(2'b00);
      step();
      check("idle_intr", intr, 0);

      // Simultaneous edges, PRIO=0 then PRIO=1
      cfg_wr(2'd2, 16'h0080);
      cfg_wr(2'd0, 16'h8003);
      cfg_wr(2'd3, 16'h0000);
      push(16'h0040, 2'b01);
      push(16'h0080, 2'b10);
      int0 = 1'b1; int1 = 1'b1;
      step();
      int0 = 1'b0; int1 = 1'b0;
      present_ack();
      finish_done(2'b00);
      present_ack();
      finish_done(2'b00);

      cfg_wr(2'd3, 16'h0001);
      push(16'h0080, 2'b10);
      push(16'h0040, 2'b01);
      int0 = 1'b1; int1 = 1'b1;
      step();
      int0 = 1'b0; int1 = 1'b0;
      present_ack();
      finish_done(2'b00);
      present_ack();
      finish_done(2'b00);

      // Nesting with PRIO=1
      push(16'h0040, 2'b01);
      int0 = 1'b1;
      step();
      int0 = 1'b0;
      present_ack();
      push(16'h0080, 2'b10);
      int1 = 1'b1;
      step();
      int1 = 1'b0;
      present_ack();
      finish_done(2'b01);
      finish_done(2'b00);

      // Masking by GE, then late enable
      cfg_wr(2'd0, 16'h0003);
      int1 = 1'b1;
      step();
      int1 = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("masked_intr", intr, 0);
      cfg_wr(2'd0, 16'h8003);
      check("ge_wr_edge", intr, 0);
      step();
      check("ge_next", intr, 1);
      push(16'h0080, 2'b10);
      present_ack();
      // Lower-priority edge while serving int1 must not preempt
      int0 = 1'b1;
      step();
      int0 = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("no_preempt", intr, 0);
      check("no_preempt_lvl", intLvl, 2'b10);
      finish_done(2'b00);
      push(16'h0040, 2'b01);
      present_ack();
      finish_done(2'b00);

      // int0 held high across reset produces no request
      int0 = 1'b1;
      do_reset();
      cfg_wr(2'd0, 16'h8001);
      cfg_wr(2'd1, 16'h0040);
      for (int i = 0; i < 4; i++) step();
      check("held_intr", intr, 0);
      int0 = 1'b0;
      step();

      // Reset while a request is pending in REQ
      push(16'h0040, 2'b01);
      int0 = 1'b1;
      step();
      int0 = 1'b0;
      wait_req(l);
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      check("rreq_intr", intr, 0);
      check("rreq_vec", intVector, 0);
      check("rreq_lvl", intLvl, 0);

      // Readback
      cfg_wr(2'd2, 16'hBEEF);
      cfgAddr = 2'd2;
      #1;
      check("rb_vec1", cfgDataOut, 16'hBEEF);
      cfg_wr(2'd0, 16'hFFFF);
      cfgAddr = 2'd0;
      #1;
      check("rb_enable", cfgDataOut, 16'h8003);
      cfg_wr(2'd3, 16'hFFFF);
      cfgAddr = 2'd3;
      #1;
      check("rb_prio", cfgDataOut, 16'h0001);

      check("sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
